// File: rtl/cpu16_mem_pkg.sv
// Shared definitions for the CPU16 data-memory port: sequencer states and data widths.
// The fetch unit is expected to import this package as well.
package cpu16_mem_pkg;

    localparam int WORD_W        = 16;
    localparam int BYTE_W        = 8;
    localparam int MEM_BYTES_DEF = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RD_WAIT,
        ST_WR,
        ST_RESP
    } lsu_state_t;

endpackage

// File: rtl/byte_lane_merge.sv
// Byte-lane helper for a big-endian 16-bit memory. The byte at the access address is always the high byte.
// It builds the read-modify-write store word and the sign- or zero-extended byte-load value.
module byte_lane_merge
    import cpu16_mem_pkg::*;
(
    input  logic [BYTE_W-1:0] store_byte,
    input  logic [WORD_W-1:0] read_word,
    input  logic              sign,
    output logic [WORD_W-1:0] merged,
    output logic [WORD_W-1:0] ext_load
);

    assign merged   = {store_byte, read_word[BYTE_W-1:0]};
    assign ext_load = {{BYTE_W{sign & read_word[WORD_W-1]}}, read_word[WORD_W-1:BYTE_W]};

endmodule

// File: rtl/load_store_unit.sv
// CPU16 load/store unit. It accepts one request at a time and sequences the data-memory strobes.
// Byte stores are done as read-modify-write. The response is held until it is accepted.
module load_store_unit
    import cpu16_mem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic              ReqByte,
    input  logic              ReqSigned,
    input  logic [WORD_W-1:0] ReqAddr,
    input  logic [WORD_W-1:0] ReqWData,
    output logic              RespValid,
    input  logic              RespReady,
    output logic [WORD_W-1:0] RespData,
    output logic              RespFault,
    output logic [WORD_W-1:0] Adresa,
    output logic [WORD_W-1:0] WriteData,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [WORD_W-1:0] ReadData
);

    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(MEM_BYTES - 2);
    localparam logic [WORD_W-1:0] BYTE_LAST = WORD_W'(MEM_BYTES - 1);

    lsu_state_t        state_reg;
    logic              write_reg;
    logic              byte_reg;
    logic              signed_reg;
    logic [WORD_W-1:0] addr_reg;
    logic [WORD_W-1:0] wdata_reg;
    logic [WORD_W-1:0] merge_reg;
    logic              resp_valid_reg;
    logic [WORD_W-1:0] resp_data_reg;
    logic              resp_fault_reg;

    logic              range_fault;
    logic [WORD_W-1:0] merged;
    logic [WORD_W-1:0] ext_load;
    logic              rd_strobe;
    logic              wr_strobe;

    byte_lane_merge u_merge (
        .store_byte (wdata_reg[BYTE_W-1:0]),
        .read_word  (ReadData),
        .sign       (signed_reg),
        .merged     (merged),
        .ext_load   (ext_load)
    );

    assign range_fault = ReqByte ? (ReqAddr > BYTE_LAST) : (ReqAddr > WORD_LAST);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg      <= ST_IDLE;
            write_reg      <= 1'b0;
            byte_reg       <= 1'b0;
            signed_reg     <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            merge_reg      <= '0;
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= '0;
            resp_fault_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (ReqValid) begin
                        write_reg     <= ReqWrite;
                        byte_reg      <= ReqByte;
                        signed_reg    <= ReqSigned;
                        addr_reg      <= ReqAddr;
                        wdata_reg     <= ReqWData;
                        resp_data_reg <= '0;
                        if (range_fault) begin
                            resp_valid_reg <= 1'b1;
                            resp_fault_reg <= 1'b1;
                            state_reg      <= ST_RESP;
                        end else if (ReqWrite && !ReqByte) begin
                            state_reg <= ST_WR;
                        end else begin
                            state_reg <= ST_RD;
                        end
                    end
                end
                ST_RD: state_reg <= ST_RD_WAIT;
                ST_RD_WAIT: begin
                    if (write_reg) begin
                        merge_reg <= merged;
                        state_reg <= ST_WR;
                    end else begin
                        resp_data_reg  <= byte_reg ? ext_load : ReadData;
                        resp_valid_reg <= 1'b1;
                        state_reg      <= ST_RESP;
                    end
                end
                ST_WR: begin
                    resp_valid_reg <= 1'b1;
                    state_reg      <= ST_RESP;
                end
                ST_RESP: begin
                    if (RespReady) begin
                        resp_valid_reg <= 1'b0;
                        resp_data_reg  <= '0;
                        resp_fault_reg <= 1'b0;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Reset also masks the strobes, so a WR cycle that is being reset never writes memory.
    assign rd_strobe = (state_reg == ST_RD) && !Reset;
    assign wr_strobe = (state_reg == ST_WR) && !Reset;

    assign MemRead   = rd_strobe;
    assign MemWrite  = wr_strobe;
    assign Adresa    = (rd_strobe || wr_strobe) ? addr_reg : '0;
    assign WriteData = wr_strobe ? (byte_reg ? merge_reg : wdata_reg) : '0;

    assign ReqReady  = (state_reg == ST_IDLE);
    assign RespValid = resp_valid_reg;
    assign RespData  = resp_data_reg;
    assign RespFault = resp_fault_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit. It drives directed and random requests against a byte-array
// memory and checks each response against an abstract model of the memory contents.
module tb_load_store_unit;

    localparam int NBYTES = 128;

    logic        clk = 1'b0;
    logic        Reset;
    logic        ReqValid, ReqReady, ReqWrite, ReqByte, ReqSigned;
    logic [15:0] ReqAddr, ReqWData;
    logic        RespValid, RespReady, RespFault;
    logic [15:0] RespData, Adresa, WriteData, ReadData;
    logic        MemWrite, MemRead;

    logic        pl_en;
    logic [6:0]  pl_addr;
    logic [7:0]  pl_data;
    logic [7:0]  mem [0:NBYTES-1];
    logic [7:0]  ref_mem [0:NBYTES-1];

    int          rd_cnt = 0, wr_cnt = 0, viol = 0;
    logic [15:0] rd_addr, wr_addr, wr_data;
    int          checks = 0, errors = 0, txn_no = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(NBYTES)) dut (
        .Clock(clk), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite), .ReqByte(ReqByte),
        .ReqSigned(ReqSigned), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
        .RespValid(RespValid), .RespReady(RespReady), .RespData(RespData), .RespFault(RespFault),
        .Adresa(Adresa), .WriteData(WriteData), .MemWrite(MemWrite), .MemRead(MemRead),
        .ReadData(ReadData)
    );

    function automatic logic [7:0] mem_byte(input int a);
        return (a < NBYTES) ? mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_byte(input int a);
        return (a < NBYTES) ? ref_mem[a] : 8'h00;
    endfunction

    // Big-endian memory with a registered read port.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (MemWrite) begin
            if (int'(Adresa) < NBYTES)     mem[Adresa]     <= WriteData[15:8];
            if (int'(Adresa) + 1 < NBYTES) mem[Adresa + 1] <= WriteData[7:0];
        end
        if (MemRead) ReadData <= {mem_byte(int'(Adresa)), mem_byte(int'(Adresa) + 1)};
    end

    always @(posedge clk) begin
        if (MemRead && MemWrite) viol <= viol + 1;
        if (!MemRead && !MemWrite && (Adresa != 16'h0 || WriteData != 16'h0)) viol <= viol + 1;
        if (MemRead) begin
            rd_cnt  <= rd_cnt + 1;
            rd_addr <= Adresa;
        end
        if (MemWrite) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= Adresa;
            wr_data <= WriteData;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_txn(input logic wr, input logic by, input logic sg,
                           input logic [15:0] addr, input logic [15:0] wd, input int stall);
        logic        fault, exp_rd, exp_wr;
        logic [15:0] exp_data, exp_wdata;
        logic [7:0]  b;
        int          exp_lat, cyc, rd0, wr0;
        fault     = by ? (int'(addr) > NBYTES - 1) : (int'(addr) > NBYTES - 2);
        exp_data  = 16'h0;
        exp_wdata = 16'h0;
        exp_rd    = 1'b0;
        exp_wr    = 1'b0;
        if (fault) begin
            exp_lat = 1;
        end else if (!wr) begin
            exp_rd  = 1'b1;
            exp_lat = 3;
            if (by) begin
                b        = ref_mem[addr];
                exp_data = (sg && b[7]) ? {8'hFF, b} : {8'h00, b};
            end else begin
                exp_data = {ref_byte(int'(addr)), ref_byte(int'(addr) + 1)};
            end
        end else if (by) begin
            exp_rd        = 1'b1;
            exp_wr        = 1'b1;
            exp_lat       = 4;
            exp_wdata     = {wd[7:0], ref_byte(int'(addr) + 1)};
            ref_mem[addr] = wd[7:0];
        end else begin
            exp_wr        = 1'b1;
            exp_lat       = 2;
            exp_wdata     = wd;
            ref_mem[addr] = wd[15:8];
            ref_mem[addr + 1] = wd[7:0];
        end

        @(negedge clk);
        check("req_ready_idle", ReqReady, 1);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        ReqValid = 1'b1; ReqWrite = wr; ReqByte = by; ReqSigned = sg; ReqAddr = addr; ReqWData = wd;
        @(negedge clk);
        ReqValid = 1'b0;
        cyc = 1;
        while (!RespValid && cyc < 12) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, exp_lat);
        check("resp_fault", RespFault, fault);
        check("resp_data", RespData, exp_data);
        check("rd_pulses", rd_cnt - rd0, exp_rd);
        check("wr_pulses", wr_cnt - wr0, exp_wr);
        if (exp_rd) check("rd_addr", rd_addr, addr);
        if (exp_wr) begin
            check("wr_addr", wr_addr, addr);
            check("wr_data", wr_data, exp_wdata);
        end
        for (int k = 0; k < stall; k++) begin
            ReqValid = 1'b1; ReqWrite = 1'b0; ReqByte = 1'b0; ReqAddr = 16'h0;
            check("stall_valid", RespValid, 1);
            check("stall_data", RespData, exp_data);
            check("stall_fault", RespFault, fault);
            check("stall_req_ready", ReqReady, 0);
            @(negedge clk);
        end
        RespReady = 1'b1;
        check("retire_req_ready", ReqReady, 0);
        @(negedge clk);
        RespReady = 1'b0;
        ReqValid  = 1'b0;
        check("resp_dropped", RespValid, 0);
        check("idle_after", ReqReady, 1);
        check("no_extra_rd", rd_cnt - rd0, exp_rd);
        txn_no++;
        $display("txn %0d wr=%0b byte=%0b sgn=%0b addr=%0d wdata=%04h -> fault=%0b data=%04h lat=%0d",
                 txn_no, wr, by, sg, addr, wd, RespFault, exp_data, cyc);
    endtask

    initial begin
        int bad, wr0;
        logic r_wr, r_by, r_sg;
        logic [15:0] r_addr;
        Reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqByte = 1'b0; ReqSigned = 1'b0;
        ReqAddr = 16'h0; ReqWData = 16'h0; RespReady = 1'b0;
        pl_en = 1'b0; pl_addr = 7'h0; pl_data = 8'h0;

        for (int i = 0; i < NBYTES; i++) begin
            @(negedge clk);
            pl_en   = 1'b1;
            pl_addr = 7'(i);
            pl_data = (i == 6) ? 8'h80 : 8'($urandom);
            ref_mem[i] = pl_data;
        end
        @(negedge clk);
        pl_en = 1'b0;
        check("rst_req_ready", ReqReady, 1);
        check("rst_resp_valid", RespValid, 0);
        check("rst_resp_fault", RespFault, 0);
        check("rst_resp_data", RespData, 0);
        check("rst_mem_read", MemRead, 0);
        check("rst_mem_write", MemWrite, 0);
        check("rst_adresa", Adresa, 0);
        check("rst_write_data", WriteData, 0);
        Reset = 1'b0;

        run_txn(1, 0, 0, 16'd4, 16'hBEEF, 0);
        check("mem4", mem[4], 8'hBE);
        check("mem5", mem[5], 8'hEF);
        run_txn(0, 0, 0, 16'd4, 16'h0000, 0);
        run_txn(1, 1, 0, 16'd4, 16'h0012, 0);
        run_txn(0, 0, 0, 16'd4, 16'h0000, 0);
        run_txn(0, 1, 1, 16'd6, 16'h0000, 0);
        run_txn(0, 1, 0, 16'd6, 16'h0000, 0);
        run_txn(0, 0, 0, 16'd127, 16'h0000, 0);
        run_txn(1, 0, 0, 16'd127, 16'h1234, 0);
        run_txn(0, 1, 0, 16'd128, 16'h0000, 0);
        run_txn(1, 1, 0, 16'd128, 16'h0055, 0);
        run_txn(0, 1, 1, 16'd127, 16'h0000, 0);
        run_txn(1, 1, 0, 16'd127, 16'h00A5, 0);
        run_txn(0, 0, 0, 16'd126, 16'h0000, 5);
        run_txn(0, 0, 0, 16'hFFFF, 16'h0000, 2);

        // Reset during the RD_WAIT cycle of a byte store.
        wr0 = wr_cnt;
        @(negedge clk);
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqByte = 1'b1; ReqAddr = 16'd8; ReqWData = 16'h0055;
        @(negedge clk);
        ReqValid = 1'b0;
        @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        check("rmw_rst_req_ready", ReqReady, 1);
        check("rmw_rst_resp_valid", RespValid, 0);
        check("rmw_rst_resp_data", RespData, 0);
        check("rmw_rst_mem_write", MemWrite, 0);
        check("rmw_rst_adresa", Adresa, 0);
        Reset = 1'b0;
        @(negedge clk);
        check("rmw_rst_no_write", wr_cnt - wr0, 0);
        check("rmw_rst_mem8", mem[8], ref_mem[8]);
        check("rmw_rst_no_resp", RespValid, 0);

        // Reset coinciding with the WR cycle of a word store.
        @(negedge clk);
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqByte = 1'b0; ReqAddr = 16'd10; ReqWData = 16'hDEAD;
        @(negedge clk);
        ReqValid = 1'b0;
        Reset = 1'b1;
        #1;
        check("wr_rst_mem_write", MemWrite, 0);
        check("wr_rst_write_data", WriteData, 0);
        @(negedge clk);
        Reset = 1'b0;
        check("wr_rst_mem10", mem[10], ref_mem[10]);
        check("wr_rst_mem11", mem[11], ref_mem[11]);
        run_txn(0, 0, 0, 16'd10, 16'h0000, 0);
        run_txn(1, 1, 0, 16'd8, 16'h00C3, 1);

        for (int n = 0; n < 40; n++) begin
            r_wr   = 1'($urandom);
            r_by   = 1'($urandom);
            r_sg   = 1'($urandom);
            r_addr = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(124, 131))
                                                 : 16'($urandom_range(0, NBYTES - 1));
            run_txn(r_wr, r_by, r_sg, r_addr, 16'($urandom), $urandom_range(0, 2));
        end

        @(negedge clk);
        bad = 0;
        for (int i = 0; i < NBYTES; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("mem_final", bad, 0);
        check("strobe_protocol", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side controller for the CPU16 data memory port. It accepts one load or store request at a time from the execute stage through a valid/ready handshake and sequences the memory's `Adresa`/`WriteData`/`MemWrite`/`MemRead` strobes. It captures the registered `ReadData` and returns a response with data or a fault flag. Byte stores are performed as read-modify-write, because the memory always writes a 16-bit big-endian word (byte at `Adresa` = bits 15:8, byte at `Adresa+1` = bits 7:0).

## Interface
- `MEM_BYTES`, 128, data memory size in bytes; legal byte addresses are 0..MEM_BYTES-1.
- `Clock`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `ReqValid`  in  1  request present.
- `ReqReady`  out  1  unit can accept a request; high only in IDLE.
- `ReqWrite`  in  1  1 = store, 0 = load.
- `ReqByte`  in  1  1 = byte access, 0 = word access.
- `ReqSigned`  in  1  byte loads only; 1 = sign-extend, 0 = zero-extend.
- `ReqAddr`  in  16  byte address.
- `ReqWData`  in  16  store data; byte stores use bits 7:0.
- `RespValid`  out  1  response present; held until accepted.
- `RespReady`  in  1  response accepted.
- `RespData`  out  16  load result; 0 for stores and faults.
- `RespFault`  out  1  address out of range; no memory access was made.
- `Adresa`  out  16  memory address.
- `WriteData`  out  16  memory write word.
- `MemWrite`  out  1  memory write strobe.
- `MemRead`  out  1  memory read strobe.
- `ReadData`  in  16  memory read word; valid the cycle after `MemRead`.

## Operation
- States: IDLE, RD, RD_WAIT, WR, RESP.
- IDLE: `ReqReady`=1. When `ReqValid`=1, latch all request fields and perform the range check:
  - Word access faults if addr > MEM_BYTES-2.
  - Byte access faults if addr > MEM_BYTES-1.
  - Fault: go to RESP with `RespFault`=1 and `RespData`=0.
  - Word store: go to WR.
  - Any load or byte store: go to RD.
- RD: `MemRead`=1, `Adresa`=latched addr. Next state is RD_WAIT.
- RD_WAIT: `ReadData` is valid.
  - Word load: `RespData`=`ReadData`.
  - Byte load: `RespData` = {8 × (ReqSigned & ReadData[15]), ReadData[15:8]}; the byte at addr is always the high byte. Go to RESP.
  - Byte store: latch merge = {ReqWData[7:0], ReadData[7:0]}, then go to WR.
- WR: `MemWrite`=1, `Adresa`=addr. `WriteData` is the merge word for byte stores and ReqWData for word stores. Next state is RESP.
- RESP: `RespValid`=1. Return to IDLE on `RespReady`=1.
- `MemRead` and `MemWrite` are never high in the same cycle, and are never high outside RD/WR.
- `Adresa` and `WriteData` are 0 when no strobe is active.
- Addresses are never wrapped. An out-of-range request produces no memory strobe.

## Timing
- Reset: state becomes IDLE. `ReqReady`=1; `RespValid`, `RespFault`, `RespData`, `MemRead`, `MemWrite`, `Adresa`, and `WriteData` are all 0.
- Reset mid-operation: the request in progress is abandoned and no response is issued. A WR cycle coinciding with asserted `Reset` must drive `MemWrite`=0.
- Latency, measured from the accept edge to the first `RespValid` cycle:
  - Word store: 2 cycles.
  - Load: 3 cycles.
  - Byte store: 4 cycles.
  - Fault: 1 cycle.
- `RespData`/`RespFault` are registered and stable while `RespValid`=1.
- No request is accepted in the cycle that `RespReady` retires a response. The next accept is possible one cycle later, in IDLE.
- Memory strobes are decoded from registered state and latched fields, so there is no combinational path from `ReqValid` to the memory port.

## Structure
- Package `cpu16_mem_pkg`: state enum `lsu_state_t`, `MEM_BYTES` default, `WORD_W`=16, `BYTE_W`=8.
- Sub-module `byte_lane_merge`, purely combinational:
  - Inputs: store byte, read word, signed flag.
  - Outputs: merged store word and extended load value.
  - Reused by the future instruction fetch unit.

## Test plan
- Word store 0xBEEF @ addr 4, then word load @ 4: strobes follow WR then RD; memory holds bytes [4]=0xBE, [5]=0xEF; load returns 0xBEEF after 3 cycles.
- Byte store 0x12 @ addr 4 over 0xBEEF: RD, RD_WAIT, WR sequence; WriteData=0x12EF; a following word load returns 0x12EF.
- Byte load of 0x80 @ addr 6:
  - With ReqSigned=1, returns 0xFF80.
  - With ReqSigned=0, returns 0x0080.
- Word access @ 127 and byte access @ 128: RespFault=1, RespData=0, no MemRead/MemWrite pulse. A byte access @ 127 succeeds.
- RespReady held low for 5 cycles: RespValid and data stay stable, ReqReady stays 0, and a second ReqValid is not accepted until the cycle after the response retires.
- Reset asserted during a byte-store RD_WAIT: no MemWrite occurs, memory is unchanged, all outputs hold their reset values, and the next request completes normally.
